// File: rtl/board_ram_arbiter_if.sv
// rtl/board_ram_arbiter_if.sv - port bundle between board_ram_arbiter, its clients and the board RAM
//
// Purpose: groups the VGA fetch port, the game access port, the clear control
// and the single RAM port into one bundle.
// Modports:
//    slave  - the arbiter: takes vga/game/clear requests and ram_rdata, drives
//             vga_data, game_gnt/rvalid/rdata, clear_busy/done and the RAM port
//    master - the clients and RAM model: the opposite directions
interface board_ram_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 3
);
   logic              vga_valid;
   logic [5:0]        vga_x;
   logic [5:0]        vga_y;
   logic [DATA_W-1:0] vga_data;

   logic              game_req;
   logic              game_we;
   logic [5:0]        game_x;
   logic [5:0]        game_y;
   logic [DATA_W-1:0] game_wdata;
   logic              game_gnt;
   logic              game_rvalid;
   logic [DATA_W-1:0] game_rdata;

   logic              clear_start;
   logic              clear_busy;
   logic              clear_done;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  vga_valid, vga_x, vga_y,
      output vga_data,
      input  game_req, game_we, game_x, game_y, game_wdata,
      output game_gnt, game_rvalid, game_rdata,
      input  clear_start,
      output clear_busy, clear_done,
      output ram_addr, ram_we, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output vga_valid, vga_x, vga_y,
      input  vga_data,
      output game_req, game_we, game_x, game_y, game_wdata,
      input  game_gnt, game_rvalid, game_rdata,
      output clear_start,
      input  clear_busy, clear_done,
      input  ram_addr, ram_we, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/board_ram_arbiter.sv
// rtl/board_ram_arbiter.sv - one-slot-per-cycle arbiter for the 64x64 board-state RAM
//
// Purpose: shares the single-port board RAM between the VGA scanner (read-only,
// highest priority unless a game request has waited MAX_WAIT cycles), the game
// updater (read/write) and a full-board fill sequence started by clear_start.
// Ports:
//    clk   - 25 MHz pixel clock
//    reset - asynchronous, active-low
//    bus   - board_ram_arbiter_if.slave: VGA fetch, game access, clear control,
//            and the RAM port (ram_addr/ram_we/ram_wdata out, ram_rdata in)
module board_ram_arbiter #(
   parameter int                ADDR_W     = 12,
   parameter int                DATA_W     = 3,
   parameter int                MAX_WAIT   = 4,
   parameter logic [DATA_W-1:0] FILL_VALUE = 3'd1
) (
   input  logic                clk,
   input  logic                reset,
   board_ram_arbiter_if.slave  bus
);
   localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
   logic [ADDR_W-1:0] last_addr;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic [ADDR_W-1:0] vga_addr, game_addr;
   logic              vga_need, forced, vga_sel, game_sel, clr_sel, last_clr;
   logic              vga_pend, rd_pend;
   logic [DATA_W-1:0] vga_q, rdata_q;

   assign vga_addr  = {bus.vga_y, bus.vga_x};
   assign game_addr = {bus.game_y, bus.game_x};

   // Slot decision and next-state
   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      wait_nxt     = wait_cnt;

      // VGA only needs the RAM when it moves to a cell it has not fetched yet
      vga_need = bus.vga_valid && (vga_addr != last_addr);
      // A starved game request overrides VGA, but never while clearing
      forced   = (state == IDLE) && bus.game_req && (wait_cnt >= MAX_WAIT_V);
      vga_sel  = vga_need && !forced;
      game_sel = !vga_sel && bus.game_req && (state == IDLE);
      clr_sel  = !vga_sel && (state == CLEAR);
      last_clr = clr_sel && (clr_addr == '1);

      case (state)
         IDLE: begin
            if (bus.clear_start) begin
               state_nxt    = CLEAR;
               clr_addr_nxt = '0;
            end
         end
         CLEAR: begin
            if (clr_sel) begin
               clr_addr_nxt = clr_addr + 1'b1;
               if (last_clr) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Waiting is only accounted while the game could have been served
      if (!bus.game_req || game_sel) begin
         wait_nxt = '0;
      end else if ((state == IDLE) && (wait_cnt < MAX_WAIT_V)) begin
         wait_nxt = wait_cnt + 1'b1;
      end
   end

   // RAM port and pulse outputs; forced low while reset is asserted so the
   // RAM sees no access the instant reset falls
   always_comb begin
      bus.ram_addr  = '0;
      bus.ram_we    = 1'b0;
      bus.ram_wdata = '0;
      if (reset) begin
         if (vga_sel) begin
            bus.ram_addr = vga_addr;
         end else if (game_sel) begin
            bus.ram_addr  = game_addr;
            bus.ram_we    = bus.game_we;
            bus.ram_wdata = bus.game_wdata;
         end else if (clr_sel) begin
            bus.ram_addr  = clr_addr;
            bus.ram_we    = 1'b1;
            bus.ram_wdata = FILL_VALUE;
         end
      end
      bus.game_gnt    = reset && game_sel;
      bus.clear_done  = reset && last_clr;
      bus.game_rvalid = rd_pend;
      bus.game_rdata  = rd_pend ? bus.ram_rdata : rdata_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         clr_addr  <= '0;
         wait_cnt  <= '0;
         last_addr <= '1;
         vga_pend  <= 1'b0;
         rd_pend   <= 1'b0;
         vga_q     <= '0;
         rdata_q   <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
         wait_cnt <= wait_nxt;
         if (vga_sel) begin
            last_addr <= vga_addr;
         end
         // ram_rdata arrives the cycle after the address; register it once more
         vga_pend <= vga_sel;
         if (vga_pend) begin
            vga_q <= bus.ram_rdata;
         end
         rd_pend <= game_sel && !bus.game_we;
         if (rd_pend) begin
            rdata_q <= bus.ram_rdata;
         end
      end
   end

   assign bus.vga_data   = vga_q;
   assign bus.clear_busy = (state == CLEAR);
endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb/tb_board_ram_arbiter.sv - self-checking bench for board_ram_arbiter with a board-level reference model
module tb_board_ram_arbiter;
   localparam int N = 4096;

   logic clk = 1'b0;
   logic reset;
   always #20 clk = ~clk;

   board_ram_arbiter_if bus ();
   board_ram_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

   // Write-first synchronous board RAM
   logic [2:0] mem [N];
   logic       preload_go;
   always @(posedge clk) begin
      if (preload_go) begin
         for (int i = 0; i < N; i++) mem[i] <= 3'(i);
      end else if (bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_wdata;
      end
      bus.ram_rdata <= bus.ram_we ? bus.ram_wdata : mem[bus.ram_addr];
   end

   // Reference model: board contents plus who owns each cycle's slot
   logic [2:0]  board [N];
   logic [11:0] m_last;
   int          m_wait, m_caddr;
   bit          m_clear, m_stage_v, m_rvalid;
   logic [2:0]  m_vga_data, m_stage_val, m_rdata;
   int          checks = 0, errors = 0;
   int          busy_cycles = 0, done_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [11:0] vkey, gkey;
      bit vneed, forced, vwin, gwin, cwin, done, was_clear;
      if (preload_go) for (int i = 0; i < N; i++) board[i] = 3'(i);
      if (!reset) begin
         m_last = 12'hFFF; m_wait = 0; m_clear = 0; m_caddr = 0;
         m_vga_data = 3'd0; m_stage_v = 0; m_stage_val = 3'd0; m_rvalid = 0; m_rdata = 3'd0;
         check("rst_ram_we", bus.ram_we, 0);
         check("rst_game_gnt", bus.game_gnt, 0);
         check("rst_rvalid", bus.game_rvalid, 0);
         check("rst_rdata", bus.game_rdata, 0);
         check("rst_vga_data", bus.vga_data, 0);
         check("rst_clear_busy", bus.clear_busy, 0);
         check("rst_clear_done", bus.clear_done, 0);
      end else begin
         vkey = {bus.vga_y, bus.vga_x};
         gkey = {bus.game_y, bus.game_x};
         was_clear = m_clear;
         vneed  = bus.vga_valid && (vkey != m_last);
         forced = !m_clear && bus.game_req && (m_wait >= 4);
         vwin   = vneed && !forced;
         gwin   = !vwin && bus.game_req && !m_clear;
         cwin   = !vwin && m_clear;
         done   = cwin && (m_caddr == N - 1);

         check("ram_we", bus.ram_we, (gwin && bus.game_we) || cwin);
         if (vwin) check("ram_addr_vga", bus.ram_addr, vkey);
         if (gwin) check("ram_addr_game", bus.ram_addr, gkey);
         if (cwin) check("ram_addr_clear", bus.ram_addr, 32'(m_caddr));
         if (gwin && bus.game_we) check("ram_wdata_game", bus.ram_wdata, bus.game_wdata);
         if (cwin) check("ram_wdata_clear", bus.ram_wdata, 1);
         check("game_gnt", bus.game_gnt, gwin);
         check("game_rvalid", bus.game_rvalid, m_rvalid);
         check("game_rdata", bus.game_rdata, m_rdata);
         check("vga_data", bus.vga_data, m_vga_data);
         check("clear_busy", bus.clear_busy, m_clear);
         check("clear_done", bus.clear_done, done);
         busy_cycles += int'(bus.clear_busy);
         done_count  += int'(bus.clear_done);

         // advance to the next cycle
         if (m_stage_v) m_vga_data = m_stage_val;
         m_stage_v   = vwin;
         m_stage_val = board[vkey];
         m_rvalid    = gwin && !bus.game_we;
         if (gwin && !bus.game_we) m_rdata = board[gkey];
         if (gwin && bus.game_we) board[gkey] = bus.game_wdata;
         if (cwin) begin
            board[m_caddr] = 3'd1;
            if (done) m_clear = 0;
            m_caddr++;
         end
         if (!was_clear && bus.clear_start) begin
            m_clear = 1; m_caddr = 0;
         end
         if (!bus.game_req || gwin) m_wait = 0;
         else if (!was_clear && m_wait < 4) m_wait++;
         if (vwin) m_last = vkey;
      end
   endtask

   task automatic sample(); @(negedge clk); model_step(); endtask
   task automatic next();   @(posedge clk); #1; endtask
   task automatic cyc();    sample(); next(); endtask

   task automatic game_op(input bit we, input int x, input int y, input logic [2:0] wd,
                          output int waited, output logic [11:0] addr, output bit wr);
      bus.game_req = 1; bus.game_we = we; bus.game_x = 6'(x); bus.game_y = 6'(y); bus.game_wdata = wd;
      waited = -1; addr = '0; wr = 0;
      for (int k = 0; k < 6000; k++) begin
         sample();
         if (bus.game_gnt) begin
            waited = k; addr = bus.ram_addr; wr = bus.ram_we;
            next();
            break;
         end
         next();
      end
      bus.game_req = 0;
      check("game_op_granted", waited >= 0, 1);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, cnt, b0, d0, bad, busy_at;
      logic [11:0] a;
      bit wr;
      reset = 0; preload_go = 0;
      bus.vga_valid = 0; bus.vga_x = 0; bus.vga_y = 0;
      bus.game_req = 0; bus.game_we = 0; bus.game_x = 0; bus.game_y = 0; bus.game_wdata = 0;
      bus.clear_start = 0;
      next(); cyc(); cyc();
      preload_go = 1; cyc(); preload_go = 0;
      reset = 1;
      cyc();

      // 1: VGA sweep row 5, data = x[2:0] two cycles later
      bus.vga_valid = 1; bus.vga_y = 6'd5;
      for (int x = 0; x < 64; x++) begin bus.vga_x = 6'(x); cyc(); end
      cyc(); sample();
      check("t1_last_vga_data", bus.vga_data, 7);
      next();
      bus.vga_valid = 0;
      cyc();

      // 2: game write then read back
      game_op(1, 10, 20, 3'd4, w, a, wr);
      check("t2_wait", w, 0);
      check("t2_addr", a, 12'h50A);
      check("t2_we", wr, 1);
      game_op(0, 10, 20, 3'd0, w, a, wr);
      sample();
      check("t2_rvalid", bus.game_rvalid, 1);
      check("t2_rdata", bus.game_rdata, 4);
      next();

      // 3: starvation against a moving VGA address
      bus.vga_valid = 1; bus.vga_y = 6'd7; bus.vga_x = 6'd0;
      bus.game_req = 1; bus.game_we = 0; bus.game_x = 6'd1; bus.game_y = 6'd1;
      w = -1;
      for (int k = 0; k < 20; k++) begin
         sample();
         if (bus.game_gnt) begin w = k; next(); break; end
         next();
         bus.vga_x = bus.vga_x + 6'd1;
      end
      bus.game_req = 0;
      check("t3_gnt_cycle", w, 4);
      cyc(); cyc();

      // 6: fixed VGA address, game served every cycle
      bus.vga_x = 6'd3; bus.vga_y = 6'd3;
      cyc(); cyc();
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         bus.game_req = 1; bus.game_we = 1'($urandom); bus.game_x = 6'($urandom);
         bus.game_y = 6'($urandom); bus.game_wdata = 3'($urandom);
         sample();
         cnt += int'(bus.game_gnt);
         next();
      end
      bus.game_req = 0; bus.vga_valid = 0;
      check("t6_gnt_count", cnt, 8);
      cyc();

      // 4: full clear, extra clear_start ignored, game waits for completion
      b0 = busy_cycles; d0 = done_count;
      bus.clear_start = 1; cyc(); bus.clear_start = 0;
      repeat (10) cyc();
      bus.game_req = 1; bus.game_we = 0; bus.game_x = 6'd5; bus.game_y = 6'd5;
      w = -1; busy_at = 1;
      for (int k = 0; k < 5000; k++) begin
         bus.clear_start = (k == 5);
         sample();
         if (bus.game_gnt) begin w = k; busy_at = int'(bus.clear_busy); next(); break; end
         next();
      end
      bus.game_req = 0; bus.clear_start = 0;
      check("t4_gnt_after_clear", w >= 0, 1);
      check("t4_busy_at_gnt", busy_at, 0);
      check("t4_busy_cycles", busy_cycles - b0, 4096);
      check("t4_done_count", done_count - d0, 1);
      bad = 0;
      for (int i = 0; i < N; i++) if (mem[i] !== 3'd1) bad++;
      check("t4_cells_filled", bad, 0);
      game_op(0, 0, 0, 3'd0, w, a, wr);   sample(); check("t4_read_0", bus.game_rdata, 1); next();
      game_op(0, 63, 63, 3'd0, w, a, wr); sample(); check("t4_read_fff", bus.game_rdata, 1); next();

      // 5: reset while the fill is at address 100
      preload_go = 1; cyc(); preload_go = 0;
      d0 = done_count;
      bus.clear_start = 1; cyc(); bus.clear_start = 0;
      repeat (100) cyc();
      check("t5_addr_before_reset", bus.ram_addr, 100);
      #1 reset = 0;
      #1;
      check("t5_async_we", bus.ram_we, 0);
      check("t5_async_busy", bus.clear_busy, 0);
      check("t5_async_addr", bus.ram_addr, 0);
      cyc(); cyc();
      reset = 1;
      cyc(); cyc();
      check("t5_no_done", done_count - d0, 0);
      bad = 0;
      for (int i = 0; i < N; i++) begin
         if (i < 100 && mem[i] !== 3'd1) bad++;
         if (i >= 100 && mem[i] !== 3'(i)) bad++;
      end
      check("t5_cells", bad, 0);

      // Random traffic with one clear in the middle
      begin
         bit gseen = 0;
         for (int c = 0; c < 9000; c++) begin
            if (gseen) bus.game_req = 0;
            if (!bus.game_req && ($urandom % 3) == 0) begin
               bus.game_req = 1; bus.game_we = 1'($urandom);
               bus.game_x = 6'($urandom_range(0, 7)); bus.game_y = 6'($urandom_range(0, 3));
               bus.game_wdata = 3'($urandom);
            end
            bus.vga_valid = ($urandom % 4) != 0;
            if ($urandom % 2 == 1) begin
               bus.vga_x = 6'($urandom_range(0, 7)); bus.vga_y = 6'($urandom_range(0, 3));
            end
            bus.clear_start = (c == 300) || (c == 310);
            sample();
            gseen = bus.game_gnt;
            next();
         end
         bus.game_req = 0; bus.vga_valid = 0; bus.clear_start = 0;
         cyc(); cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
